// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer sound sequencer: event codes, note-table entry,
// sequence lengths and sequencer states.
package buzzer_pkg;

    localparam int unsigned HP_W       = 16;
    localparam int unsigned NOTE_DUR_W = 10;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NOTE_W     = HP_W + NOTE_DUR_W + 1;

    localparam int unsigned LEN_CORRECT  = 2;
    localparam int unsigned LEN_WRONG    = 1;
    localparam int unsigned LEN_GAMEOVER = 6;

    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_CORRECT  = 2'd1,
        EV_WRONG    = 2'd2,
        EV_GAMEOVER = 2'd3
    } event_e;

    typedef struct packed {
        logic [HP_W-1:0]       half_period;
        logic [NOTE_DUR_W-1:0] dur_ticks;
        logic                  last;
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

    // Clocks per half-period of a square wave at freq_hz; 0 Hz is a rest.
    function automatic logic [HP_W-1:0] half_period_of(input int unsigned clk_hz,
                                                       input int unsigned freq_hz);
        if (freq_hz == 0) begin
            return '0;
        end
        return HP_W'(clk_hz / (2 * freq_hz));
    endfunction

endpackage

// File: rtl/buzzer_note_rom.sv
// Combinational note table: (event, note index) -> {half_period, dur_ticks, last}.
// Melodies are expressed in Hz so the table follows CLK_HZ.
module buzzer_note_rom
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic [1:0]        ev,
    input  logic [IDX_W-1:0]  idx,
    output logic [NOTE_W-1:0] entry
);

    note_t entry_c;

    function automatic note_t note(input int unsigned freq_hz,
                                   input int unsigned dur,
                                   input logic        last);
        note_t n;
        n.half_period = half_period_of(CLK_HZ, freq_hz);
        n.dur_ticks   = NOTE_DUR_W'(dur);
        n.last        = last;
        return n;
    endfunction

    // Out-of-range lookups return a silent terminal entry.
    always_comb begin
        entry_c = note(0, 0, 1'b1);
        case (ev)
            EV_CORRECT: begin
                case (idx)
                    IDX_W'(0): entry_c = note(2000, 50, 1'b0);
                    IDX_W'(1): entry_c = note(2500, 50, 1'b1);
                    default:   entry_c = note(0, 0, 1'b1);
                endcase
            end
            EV_WRONG: begin
                case (idx)
                    IDX_W'(0): entry_c = note(500, 150, 1'b1);
                    default:   entry_c = note(0, 0, 1'b1);
                endcase
            end
            EV_GAMEOVER: begin
                case (idx)
                    IDX_W'(0): entry_c = note(1000, 300, 1'b0);
                    IDX_W'(1): entry_c = note(0,     50, 1'b0);
                    IDX_W'(2): entry_c = note(800,  300, 1'b0);
                    IDX_W'(3): entry_c = note(0,     50, 1'b0);
                    IDX_W'(4): entry_c = note(600,  300, 1'b0);
                    IDX_W'(5): entry_c = note(400,  600, 1'b1);
                    default:   entry_c = note(0, 0, 1'b1);
                endcase
            end
            default: entry_c = note(0, 0, 1'b1);
        endcase
    end

    assign entry = entry_c;

endmodule

// File: rtl/buzzer_sound_sequencer.sv
// Buzzer sound sequencer: arbitrates game sound requests by fixed priority with
// preemption and plays note patterns. Define BUZZER_SEQ_MUTE_EN to add a `mute` input.
module buzzer_sound_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_DIV = 50_000,
    parameter int unsigned DUR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        correct_hit,
    input  logic        wrong_hit,
    input  logic        game_over,
`ifdef BUZZER_SEQ_MUTE_EN
    input  logic        mute,
`endif
    output logic [15:0] tone_half_period,
    output logic        tone_en,
    output logic        busy,
    output logic [1:0]  cur_event
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e             state;
    event_e             play_ev;
    logic [IDX_W-1:0]   note_idx;
    logic [PRE_W-1:0]   presc;
    logic [DUR_W-1:0]   dur;
    logic               is_last;
    logic [2:0]         pend;      // {game_over, wrong, correct}

    note_t              entry_c;
    event_e             top_ev_c;
    logic [2:0]         clr_c;
    logic               launch_c;
    logic               preempt_c;
    logic               wrap_c;
    logic               note_end_c;
    logic               mute_c;

`ifdef BUZZER_SEQ_MUTE_EN
    assign mute_c = mute;
`else
    assign mute_c = 1'b0;
`endif

    buzzer_note_rom #(
        .CLK_HZ (CLK_HZ)
    ) u_rom (
        .ev    (play_ev),
        .idx   (note_idx),
        .entry (entry_c)
    );

    // Highest pending request; it launches from IDLE or preempts an equal/lower sequence.
    always_comb begin
        top_ev_c = EV_NONE;
        clr_c    = 3'b000;
        if (pend[2]) begin
            top_ev_c = EV_GAMEOVER;
        end else if (pend[1]) begin
            top_ev_c = EV_WRONG;
        end else if (pend[0]) begin
            top_ev_c = EV_CORRECT;
        end
        launch_c  = (state == IDLE) && (top_ev_c != EV_NONE);
        preempt_c = (state != IDLE) && (top_ev_c != EV_NONE) && (top_ev_c >= play_ev);
        if (launch_c || preempt_c) begin
            case (top_ev_c)
                EV_GAMEOVER: clr_c = 3'b100;
                EV_WRONG:    clr_c = 3'b010;
                EV_CORRECT:  clr_c = 3'b001;
                default:     clr_c = 3'b000;
            endcase
        end
    end

    // Note ends on the tick that takes the duration to zero, so each note spans
    // its LOAD cycle plus dur_ticks*TICK_DIV PLAY cycles.
    assign wrap_c     = (presc == PRE_W'(TICK_DIV - 1));
    assign note_end_c = (dur == '0) || (wrap_c && (dur == DUR_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            play_ev          <= EV_NONE;
            note_idx         <= '0;
            presc            <= '0;
            dur              <= '0;
            is_last          <= 1'b0;
            pend             <= 3'b000;
            tone_half_period <= '0;
            tone_en          <= 1'b0;
            busy             <= 1'b0;
            cur_event        <= 2'd0;
        end else begin
            // A pulse arriving in the launch cycle re-arms its flag.
            pend <= (pend & ~clr_c) | {game_over, wrong_hit, correct_hit};

            case (state)
                IDLE: begin
                    tone_half_period <= '0;
                    tone_en          <= 1'b0;
                    busy             <= 1'b0;
                    cur_event        <= 2'd0;
                    if (launch_c) begin
                        play_ev  <= top_ev_c;
                        note_idx <= '0;
                        state    <= LOAD;
                    end
                end

                LOAD: begin
                    if (preempt_c) begin
                        play_ev  <= top_ev_c;
                        note_idx <= '0;
                    end else begin
                        tone_half_period <= entry_c.half_period;
                        tone_en          <= (entry_c.half_period != '0) && !mute_c;
                        busy             <= 1'b1;
                        cur_event        <= play_ev;
                        dur              <= DUR_W'(entry_c.dur_ticks);
                        is_last          <= entry_c.last;
                        presc            <= '0;
                        state            <= PLAY;
                    end
                end

                PLAY: begin
                    tone_en <= (tone_half_period != '0) && !mute_c;
                    if (preempt_c) begin
                        play_ev  <= top_ev_c;
                        note_idx <= '0;
                        state    <= LOAD;
                    end else if (note_end_c) begin
                        presc <= '0;
                        dur   <= '0;
                        if (is_last) begin
                            state <= IDLE;
                        end else begin
                            note_idx <= note_idx + IDX_W'(1);
                            state    <= LOAD;
                        end
                    end else if (wrap_c) begin
                        presc <= '0;
                        dur   <= dur - DUR_W'(1);
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_sound_sequencer.sv
// Bench for buzzer_sound_sequencer with TICK_DIV=4: expected note segments are queued
// when a request is driven and compared cycle by cycle as the DUT plays them.
module tb_buzzer_sound_sequencer;

    localparam int unsigned TD = 4;
    localparam logic [1:0] E_C = 2'd1;
    localparam logic [1:0] E_W = 2'd2;
    localparam logic [1:0] E_G = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        correct_hit;
    logic        wrong_hit;
    logic        game_over;
`ifdef BUZZER_SEQ_MUTE_EN
    logic        mute;
`endif
    logic [15:0] tone_half_period;
    logic        tone_en;
    logic        busy;
    logic [1:0]  cur_event;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [15:0] hp;
        logic        en;
        logic        busy;
        logic [1:0]  ev;
        int unsigned cycles;
    } seg_t;

    typedef struct {
        string       name;
        logic [2:0]  req;   // {game_over, wrong, correct}
        int unsigned n_ev;
        logic [5:0]  ord;   // play order, first event in [1:0]
    } vec_t;

    seg_t sb[$];
    vec_t vecs[5];

    buzzer_sound_sequencer #(
        .CLK_HZ   (50_000_000),
        .TICK_DIV (TD),
        .DUR_W    (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .correct_hit      (correct_hit),
        .wrong_hit        (wrong_hit),
        .game_over        (game_over),
`ifdef BUZZER_SEQ_MUTE_EN
        .mute             (mute),
`endif
        .tone_half_period (tone_half_period),
        .tone_en          (tone_en),
        .busy             (busy),
        .cur_event        (cur_event)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] hp, input logic en, input logic bz,
                        input logic [1:0] ev, input int unsigned cycles);
        seg_t s;
        s.hp = hp; s.en = en; s.busy = bz; s.ev = ev; s.cycles = cycles;
        sb.push_back(s);
    endtask

    task automatic push_idle(input int unsigned cycles);
        push(16'd0, 1'b0, 1'b0, 2'd0, cycles);
    endtask

    // Full expected melody of one event; en_ok=0 models a muted run.
    task automatic push_event(input logic [1:0] ev, input logic en_ok);
        case (ev)
            E_C: begin
                push(16'd12500, en_ok, 1'b1, E_C, 1 + 50 * TD);
                push(16'd10000, en_ok, 1'b1, E_C, 1 + 50 * TD);
            end
            E_W: push(16'd50000, en_ok, 1'b1, E_W, 1 + 150 * TD);
            default: begin
                push(16'd25000, en_ok, 1'b1, E_G, 1 + 300 * TD);
                push(16'd0,     1'b0,  1'b1, E_G, 1 + 50 * TD);
                push(16'd31250, en_ok, 1'b1, E_G, 1 + 300 * TD);
                push(16'd0,     1'b0,  1'b1, E_G, 1 + 50 * TD);
                push(16'd41666, en_ok, 1'b1, E_G, 1 + 300 * TD);
                push(16'd62500, en_ok, 1'b1, E_G, 1 + 600 * TD);
            end
        endcase
    endtask

    // Pop each queued segment and require the outputs to hold it for every cycle.
    task automatic run_sb(input string tag);
        seg_t        s;
        int unsigned k = 0;
        logic [19:0] got;
        logic [19:0] bad_val;
        int          bad_at;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            bad_at = -1;
            bad_val = '0;
            for (int i = 0; i < int'(s.cycles); i++) begin
                @(negedge clk);
                got = {tone_half_period, tone_en, busy, cur_event};
                if (got !== {s.hp, s.en, s.busy, s.ev} && bad_at < 0) begin
                    bad_at  = i;
                    bad_val = got;
                end
            end
            n_vec++;
            if (bad_at >= 0) begin
                n_bad++;
                $display("FAIL %s seg%0d cycle %0d: got hp=%0d en=%0b busy=%0b ev=%0d, want hp=%0d en=%0b busy=%0b ev=%0d",
                         tag, k, bad_at, bad_val[19:4], bad_val[3], bad_val[2], bad_val[1:0],
                         s.hp, s.en, s.busy, s.ev);
            end
            k++;
        end
    endtask

    task automatic pulse(input logic [2:0] req);
        @(negedge clk);
        {game_over, wrong_hit, correct_hit} = req;
        @(negedge clk);
        {game_over, wrong_hit, correct_hit} = 3'b000;
    endtask

    initial begin
        logic [5:0] o;
        rst = 1'b1;
        {game_over, wrong_hit, correct_hit} = 3'b000;
`ifdef BUZZER_SEQ_MUTE_EN
        mute = 1'b0;
`endif
        vecs[0] = '{"correct_only",  3'b001, 1, {2'd0, 2'd0, E_C}};
        vecs[1] = '{"wrong_only",    3'b010, 1, {2'd0, 2'd0, E_W}};
        vecs[2] = '{"gameover_only", 3'b100, 1, {2'd0, 2'd0, E_G}};
        vecs[3] = '{"all_three",     3'b111, 3, {E_C, E_W, E_G}};
        vecs[4] = '{"correct_wrong", 3'b011, 2, {2'd0, E_C, E_W}};

        repeat (3) @(negedge clk);
        chk("reset_hp",   32'(tone_half_period), 32'd0);
        chk("reset_en",   32'(tone_en),          32'd0);
        chk("reset_busy", 32'(busy),             32'd0);
        chk("reset_ev",   32'(cur_event),        32'd0);
        rst = 1'b0;
        push_idle(5);
        run_sb("post_reset");

        // Table: simultaneous requests play in priority order, each exactly once.
        for (int v = 0; v < 5; v++) begin
            pulse(vecs[v].req);
            @(negedge clk);
            o = vecs[v].ord;
            for (int k = 0; k < int'(vecs[v].n_ev); k++) begin
                if (k > 0) push_idle(1);
                push_event(o[2*k +: 2], 1'b1);
            end
            push_idle(20);
            run_sb(vecs[v].name);
        end

        // Higher priority preempts a playing correct; correct is dropped.
        pulse(3'b001);
        @(negedge clk);
        push(16'd12500, 1'b1, 1'b1, E_C, 60);
        run_sb("pre_correct");
        pulse(3'b010);
        @(negedge clk);
        chk("preempt_not_yet", 32'(cur_event), 32'(E_C));
        push_event(E_W, 1'b1);
        push_idle(20);
        run_sb("preempt_wrong");

        // Lower priority pulses coalesce and wait for the current sequence.
        pulse(3'b010);
        @(negedge clk);
        push(16'd50000, 1'b1, 1'b1, E_W, 100);
        run_sb("wrong_head");
        repeat (3) pulse(3'b001);
        push(16'd50000, 1'b1, 1'b1, E_W, 601 - 100 - 6);
        push_idle(1);
        push_event(E_C, 1'b1);
        push_idle(20);
        run_sb("coalesce");

        // Same event restarts at note 0; then reset mid-note silences and drops flags.
        pulse(3'b100);
        @(negedge clk);
        push(16'd25000, 1'b1, 1'b1, E_G, 1 + 300 * TD);
        push(16'd0,     1'b0, 1'b1, E_G, 1 + 50 * TD);
        push(16'd31250, 1'b1, 1'b1, E_G, 50);
        run_sb("go_head");
        pulse(3'b100);
        @(negedge clk);
        chk("restart_not_yet", 32'(tone_half_period), 32'd31250);
        push(16'd25000, 1'b1, 1'b1, E_G, 100);
        run_sb("go_restart");
        pulse(3'b001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_hp",   32'(tone_half_period), 32'd0);
        chk("async_rst_en",   32'(tone_en),          32'd0);
        chk("async_rst_busy", 32'(busy),             32'd0);
        chk("async_rst_ev",   32'(cur_event),        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_idle(20);
        run_sb("after_rst");

`ifdef BUZZER_SEQ_MUTE_EN
        // Muted run keeps timing; unmuting mid-note restores sound the next cycle.
        mute = 1'b1;
        pulse(3'b010);
        @(negedge clk);
        push_event(E_W, 1'b0);
        push_idle(20);
        run_sb("muted_wrong");
        pulse(3'b010);
        @(negedge clk);
        push(16'd50000, 1'b0, 1'b1, E_W, 100);
        run_sb("mute_head");
        mute = 1'b0;
        push(16'd50000, 1'b1, 1'b1, E_W, 501);
        push_idle(20);
        run_sb("unmuted_tail");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
